pipe_regfile_sb: RTL and testbench

Parametrised pipeline register file for the MIPS pipeline with same-cycle write-to-read bypass, a per-register pending-write scoreboard, and a defined no-write destination code. Sits between IF/ID and ID/EX: decodes rs/rt from the IF/ID instruction, writes back from MEM/WB, and tells the hazard unit whether a source register still has an in-flight writer. Stalls as a whole on `waitrequest`.

---
 rtl/pipe_regfile_sb.sv | 114 +++++++++++
 tb/tb_pipe_regfile_sb.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_regfile_sb.sv
// MIPS ID-stage register file: rs/rt decode, MEM/WB writeback with optional
// same-cycle bypass, and a per-register pending-write scoreboard for hazard detection.
module pipe_regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int LINK_REG = 31,
  parameter int BYPASS   = 1,
  parameter int MAX_PEND = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              waitrequest,
  input  logic [31:0]       id_instr,
  input  logic              rd_en,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_addr,
  input  logic [31:0]       wb_instr,
  input  logic              wb_en,
  input  logic [1:0]        wb_dst,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] rs_q,
  output logic [DATA_W-1:0] rt_q,
  output logic [DATA_W-1:0] rs_c,
  output logic [DATA_W-1:0] rt_c,
  output logic              haz_rs,
  output logic              haz_rt,
  output logic              sb_ovf,
  output logic [DATA_W-1:0] v0
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int CW    = $clog2(MAX_PEND + 1);
  localparam logic [CW-1:0] PEND_MAX = CW'(MAX_PEND);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [CW-1:0]     cnt  [DEPTH];
  logic [ADDR_W-1:0] rs_a, rt_a, wa;
  logic              wb_hit, byp_rs, byp_rt, ovf_try;
  logic [DEPTH-1:0]  inc_v, dec_v;
  logic              unused_instr_bits;

  // Pending count update; inc/dec arrive already gated against saturation/underflow.
  function automatic logic [CW-1:0] sb_next(input logic [CW-1:0] cur,
                                            input logic inc, input logic dec);
    if (inc && !dec) return cur + 1'b1;
    if (dec && !inc) return cur - 1'b1;
    return cur;
  endfunction

  function automatic logic pending(input logic [CW-1:0] c, input logic satisfied);
    return c > CW'(satisfied);
  endfunction

  assign rs_a = ADDR_W'(id_instr[25:21]);
  assign rt_a = ADDR_W'(id_instr[20:16]);
  assign unused_instr_bits = &{1'b0, id_instr[31:26], id_instr[15:0],
                               wb_instr[31:21], wb_instr[10:0]};

  always_comb begin
    wa = '0;
    case (wb_dst)
      2'b00:   wa = ADDR_W'(wb_instr[20:16]);
      2'b01:   wa = ADDR_W'(wb_instr[15:11]);
      2'b10:   wa = ADDR_W'(LINK_REG);
      default: wa = '0;
    endcase
  end

  assign wb_hit = wb_en && (wb_dst != 2'b11) && (wa != '0);
  assign byp_rs = (BYPASS != 0) && wb_hit && (wa == rs_a);
  assign byp_rt = (BYPASS != 0) && wb_hit && (wa == rt_a);

  // Stage p0: combinational read with writeback forwarding
  always_comb begin
    rs_c = '0;
    rt_c = '0;
    if (rs_a != '0) rs_c = byp_rs ? wb_data : regs[rs_a];
    if (rt_a != '0) rt_c = byp_rt ? wb_data : regs[rt_a];
  end

  assign haz_rs = pending(cnt[rs_a], byp_rs);
  assign haz_rt = pending(cnt[rt_a], byp_rt);
  assign v0     = regs[2];

  always_comb begin
    inc_v = '0;
    dec_v = '0;
    for (int i = 1; i < DEPTH; i++) begin
      inc_v[i] = iss_en && (iss_addr == ADDR_W'(i)) && (cnt[i] < PEND_MAX);
      dec_v[i] = wb_hit && (wa == ADDR_W'(i)) && (cnt[i] != '0);
    end
    ovf_try = iss_en && (iss_addr != '0) && (cnt[iss_addr] >= PEND_MAX);
  end

  // Stage p1: array write, registered read, scoreboard; reset overrides the stall
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
        cnt[i]  <= '0;
      end
      rs_q   <= '0;
      rt_q   <= '0;
      sb_ovf <= 1'b0;
    end else if (!waitrequest) begin
      if (wb_hit) regs[wa] <= wb_data;
      rs_q <= rd_en ? rs_c : '0;
      rt_q <= rd_en ? rt_c : '0;
      for (int i = 1; i < DEPTH; i++) cnt[i] <= sb_next(cnt[i], inc_v[i], dec_v[i]);
      if (ovf_try) sb_ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_regfile_sb.sv
// Directed bench for pipe_regfile_sb: bypassed and non-bypassed instances share stimulus.
module tb_pipe_regfile_sb;

  logic        clk = 1'b0;
  logic        reset, waitrequest, rd_en, iss_en, wb_en;
  logic [31:0] id_instr, wb_instr, wb_data;
  logic [4:0]  iss_addr;
  logic [1:0]  wb_dst;

  logic [31:0] rs_q, rt_q, rs_c, rt_c, v0;
  logic        haz_rs, haz_rt, sb_ovf;
  logic [31:0] nb_rs_q, nb_rt_q, nb_rs_c, nb_rt_c, nb_v0;
  logic        nb_haz_rs, nb_haz_rt, nb_sb_ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_regfile_sb #(.BYPASS(1)) u_dut (
    .clk(clk), .reset(reset), .waitrequest(waitrequest), .id_instr(id_instr),
    .rd_en(rd_en), .iss_en(iss_en), .iss_addr(iss_addr), .wb_instr(wb_instr),
    .wb_en(wb_en), .wb_dst(wb_dst), .wb_data(wb_data), .rs_q(rs_q), .rt_q(rt_q),
    .rs_c(rs_c), .rt_c(rt_c), .haz_rs(haz_rs), .haz_rt(haz_rt), .sb_ovf(sb_ovf), .v0(v0)
  );

  pipe_regfile_sb #(.BYPASS(0)) u_nb (
    .clk(clk), .reset(reset), .waitrequest(waitrequest), .id_instr(id_instr),
    .rd_en(rd_en), .iss_en(iss_en), .iss_addr(iss_addr), .wb_instr(wb_instr),
    .wb_en(wb_en), .wb_dst(wb_dst), .wb_data(wb_data), .rs_q(nb_rs_q), .rt_q(nb_rt_q),
    .rs_c(nb_rs_c), .rt_c(nb_rt_c), .haz_rs(nb_haz_rs), .haz_rt(nb_haz_rt),
    .sb_ovf(nb_sb_ovf), .v0(nb_v0)
  );

  function automatic logic [31:0] ins(input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [4:0] rd);
    return {6'd0, rs, rt, rd, 11'd0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; waitrequest = 1'b1; rd_en = 1'b0; iss_en = 1'b0; wb_en = 1'b0;
    id_instr = '0; wb_instr = '0; wb_data = '0; iss_addr = '0; wb_dst = 2'b11;

    // Reset under stall
    tick();
    reset = 1'b1; waitrequest = 1'b0; id_instr = ins(5, 31, 0); #1;
    chk("rst_rs_q", rs_q, 0);
    chk("rst_rt_q", rt_q, 0);
    chk("rst_ovf", sb_ovf, 0);
    chk("rst_haz_rs", haz_rs, 0);
    chk("rst_haz_rt", haz_rt, 0);
    chk("rst_v0", v0, 0);
    chk("rst_rs_c", rs_c, 0);
    chk("rst_rt_c", rt_c, 0);

    // Bypass: r5 <= DEADBEEF via rd, read back same cycle
    rd_en = 1'b1; id_instr = ins(5, 0, 0);
    wb_en = 1'b1; wb_dst = 2'b01; wb_instr = ins(0, 0, 5); wb_data = 32'hDEADBEEF; #1;
    chk("byp_rs_c", rs_c, 32'hDEADBEEF);
    chk("nobyp_rs_c_old", nb_rs_c, 0);
    chk("byp_rt_c_r0", rt_c, 0);
    tick();
    wb_en = 1'b0; #1;
    chk("byp_rs_q", rs_q, 32'hDEADBEEF);
    chk("nobyp_rs_q", nb_rs_q, 0);
    chk("nobyp_rs_c_new", nb_rs_c, 32'hDEADBEEF);

    // Link destination writes r31
    id_instr = ins(31, 2, 0);
    wb_en = 1'b1; wb_dst = 2'b10; wb_instr = ins(0, 0, 0); wb_data = 32'hCAFE0031; #1;
    chk("link_byp", rs_c, 32'hCAFE0031);
    chk("link_nobyp_old", nb_rs_c, 0);
    tick();
    wb_en = 1'b0; #1;
    chk("link_array", nb_rs_c, 32'hCAFE0031);

    // r2 via rt: v0 shows array only
    wb_en = 1'b1; wb_dst = 2'b00; wb_instr = ins(0, 2, 0); wb_data = 32'h22; #1;
    chk("v0_before", v0, 0);
    chk("r2_byp_rt_c", rt_c, 32'h22);
    tick();
    wb_en = 1'b0; #1;
    chk("v0_after", v0, 32'h22);

    // No-write code and r0 target
    id_instr = ins(5, 0, 0);
    wb_en = 1'b1; wb_dst = 2'b11; wb_instr = ins(0, 5, 5); wb_data = 32'h1234; #1;
    chk("nowr_comb", rs_c, 32'hDEADBEEF);
    tick();
    wb_en = 1'b0; #1;
    chk("nowr_array", nb_rs_c, 32'hDEADBEEF);
    id_instr = ins(0, 0, 0);
    wb_en = 1'b1; wb_dst = 2'b01; wb_instr = ins(0, 0, 0); wb_data = 32'h1234; #1;
    chk("r0_comb", rs_c, 0);
    tick();
    wb_en = 1'b0; #1;
    chk("r0_q", rs_q, 0);
    chk("r0_array", rs_c, 0);

    // Scoreboard on r7
    id_instr = ins(7, 0, 0);
    iss_en = 1'b1; iss_addr = 5'd7; #1;
    chk("sb_pre", haz_rs, 0);
    tick();
    tick();
    iss_en = 1'b0; #1;
    chk("sb_two", haz_rs, 1);
    wb_en = 1'b1; wb_dst = 2'b01; wb_instr = ins(0, 0, 7); wb_data = 32'h77; #1;
    chk("sb_wb1_comb", haz_rs, 1);
    tick();
    chk("sb_wb2_byp", haz_rs, 0);
    chk("sb_wb2_nobyp", nb_haz_rs, 1);
    tick();
    wb_en = 1'b0; #1;
    chk("sb_clear", haz_rs, 0);
    chk("sb_clear_nb", nb_haz_rs, 0);
    iss_en = 1'b1; tick();
    wb_en = 1'b1; tick();
    iss_en = 1'b0; wb_en = 1'b0; #1;
    chk("sb_inc_dec_keep", haz_rs, 1);
    wb_en = 1'b1; tick();
    wb_en = 1'b0; #1;
    chk("sb_final_clear", nb_haz_rs, 0);

    // Saturation on r9
    id_instr = ins(7, 9, 0);
    iss_en = 1'b1; iss_addr = 5'd9;
    tick(); tick(); tick();
    chk("sat_ovf_pre", sb_ovf, 0);
    chk("sat_haz", haz_rt, 1);
    tick();
    iss_en = 1'b0; #1;
    chk("sat_ovf", sb_ovf, 1);
    chk("sat_ovf_nb", nb_sb_ovf, 1);
    wb_en = 1'b1; wb_dst = 2'b01; wb_instr = ins(0, 0, 9); wb_data = 32'h99;
    tick(); tick();
    wb_en = 1'b0; #1;
    chk("sat_cnt_gt2", haz_rt, 1);
    wb_en = 1'b1; #1;
    chk("sat_last_byp", haz_rt, 0);
    chk("sat_last_nobyp", nb_haz_rt, 1);
    tick();
    wb_en = 1'b0; #1;
    chk("sat_cnt_was3", nb_haz_rt, 0);
    chk("sat_ovf_sticky", sb_ovf, 1);

    // Stall holds every flop
    id_instr = ins(5, 5, 0); rd_en = 1'b1; tick();
    chk("stall_pre_q", rs_q, 32'hDEADBEEF);
    waitrequest = 1'b1; id_instr = ins(31, 5, 0);
    wb_en = 1'b1; wb_dst = 2'b01; wb_instr = ins(0, 0, 5); wb_data = 32'h5555;
    iss_en = 1'b1; iss_addr = 5'd5; #1;
    chk("stall_rs_c", rs_c, 32'hCAFE0031);
    chk("stall_rt_c_byp", rt_c, 32'h5555);
    tick(); tick();
    waitrequest = 1'b0; wb_en = 1'b0; iss_en = 1'b0; rd_en = 1'b0;
    id_instr = ins(5, 0, 0); #1;
    chk("stall_q_held", rs_q, 32'hDEADBEEF);
    chk("stall_array", rs_c, 32'hDEADBEEF);
    chk("stall_cnt", haz_rs, 0);
    tick();
    chk("rden0_q", rs_q, 0);

    // Second reset clears array, counters and sticky overflow
    reset = 1'b0; waitrequest = 1'b1; tick();
    reset = 1'b1; waitrequest = 1'b0; id_instr = ins(5, 31, 0); #1;
    chk("rst2_ovf", sb_ovf, 0);
    chk("rst2_rs_c", rs_c, 0);
    chk("rst2_rt_c", rt_c, 0);
    chk("rst2_v0", v0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
